// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the IF/MEM memory bus arbiter.
//
// The `define block carries the core-wide reset/data/write-enable constants
// and the 2-bit arbiter state encodings; the package wraps the encodings in a
// typed enum and provides the fixed-priority pick function used in IDLE.
//
// Optional feature macro used elsewhere in this slice: MEM_BUS_ARBITER_TIMEOUT_EN.

`ifndef MEM_BUS_ARBITER_DEFINES
`define MEM_BUS_ARBITER_DEFINES
`define RstEnable    1'b1
`define ZeroWord     32'h0000_0000
`define WriteEnable  1'b1
`define WriteDisable 1'b0
`define ArbIdle      2'b00
`define ArbBusyMem   2'b01
`define ArbBusyIf    2'b10
`define ArbDrain     2'b11
`define ArbStateBus  1:0
`endif

package mem_bus_arbiter_pkg;

  typedef enum logic [`ArbStateBus] {
    ARB_IDLE     = `ArbIdle,
    ARB_BUSY_MEM = `ArbBusyMem,
    ARB_BUSY_IF  = `ArbBusyIf,
    ARB_DRAIN    = `ArbDrain
  } arb_state_e;

  // MEM always wins over IF: the MEM stage holds the older instruction.
  function automatic arb_state_e arb_pick(input logic mem_ok, input logic if_ok);
    arb_state_e pick;
    if (mem_ok) begin
      pick = ARB_BUSY_MEM;
    end else if (if_ok) begin
      pick = ARB_BUSY_IF;
    end else begin
      pick = ARB_IDLE;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the pipeline (IF/MEM stages), the arbiter and the
// shared memory bus.
//
// modport slave  : arbiter view (serves IF/MEM requests, drives the bus).
// modport master : environment view (pipeline stages and bus slave).
//
// IF side  : flush, if_req, if_addr -> if_rdata, if_ack, stallreq_if
// MEM side : mem_req, mem_we, mem_addr, mem_sel, mem_wdata
//            -> mem_rdata, mem_ack, stallreq_mem
// Bus side : bus_stb, bus_we, bus_addr, bus_sel, bus_wdata, bus_err
//            <- bus_rdata, bus_ack

interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int SEL_W = DATA_W / 8;

  logic              flush;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [SEL_W-1:0]  mem_sel;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              stallreq_if;
  logic              stallreq_mem;
  logic              bus_stb;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [SEL_W-1:0]  bus_sel;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ack;
  logic              bus_err;

  modport slave (
    input  flush, if_req, if_addr, mem_req, mem_we, mem_addr, mem_sel, mem_wdata,
           bus_rdata, bus_ack,
    output if_rdata, if_ack, mem_rdata, mem_ack, stallreq_if, stallreq_mem,
           bus_stb, bus_we, bus_addr, bus_sel, bus_wdata, bus_err
  );

  modport master (
    output flush, if_req, if_addr, mem_req, mem_we, mem_addr, mem_sel, mem_wdata,
           bus_rdata, bus_ack,
    input  if_rdata, if_ack, mem_rdata, mem_ack, stallreq_if, stallreq_mem,
           bus_stb, bus_we, bus_addr, bus_sel, bus_wdata, bus_err
  );

endinterface

// File: rtl/mem_bus_arbiter_arb_timeout_cnt.sv
// Bus-transaction watchdog counter for the memory bus arbiter.
// Only compiled when MEM_BUS_ARBITER_TIMEOUT_EN is defined.
//
// Ports: clk, rst (sync, active high), clear (restart at zero),
//        enable (count one stalled cycle), expired (count has reached LIMIT).
// The count saturates at LIMIT so expired stays high until the next clear.

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
module arb_timeout_cnt #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int              CNT_W   = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;

  // Stalled-cycle counter, saturating at LIMIT.
  always_ff @(posedge clk) begin
    if (rst == `RstEnable) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (enable && (cnt_r != LIMIT_C)) begin
      cnt_r <= cnt_r + ONE_C;
    end
  end

  assign expired = (cnt_r == LIMIT_C);

endmodule
`endif

// File: rtl/mem_bus_arbiter.sv
// Arbiter sharing one single-port memory bus between the IF stage (fetch)
// and the MEM stage (load/store).
//
// Ports: clk, rst (synchronous, active high)
//        arb : mem_bus_arbiter_if.slave (IF, MEM and bus signal groups)
// Behaviour: fixed priority MEM over IF, registered grant, one-cycle
// x_ack pulses, combinational stallreq_x, flush drains an in-flight fetch.
// Optional: MEM_BUS_ARBITER_TIMEOUT_EN adds a TIMEOUT-cycle watchdog that
// aborts a stalled transaction and pulses bus_err; otherwise bus_err is 0.

module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic              clk,
  input logic              rst,
  mem_bus_arbiter_if.slave arb
);
  localparam int SEL_W = DATA_W / 8;

  arb_state_e        state_r;
  arb_state_e        state_next_s;
  logic              mem_elig_s;
  logic              if_elig_s;
  logic              grant_mem_s;
  logic              grant_if_s;
  logic              ack_mem_s;
  logic              ack_if_s;
  logic              end_s;
  logic              err_s;
  logic              zero_data_s;
  logic              expired_s;

  logic              bus_stb_r;
  logic              bus_we_r;
  logic [ADDR_W-1:0] bus_addr_r;
  logic [SEL_W-1:0]  bus_sel_r;
  logic [DATA_W-1:0] bus_wdata_r;
  logic              bus_err_r;
  logic [DATA_W-1:0] if_rdata_r;
  logic              if_ack_r;
  logic [DATA_W-1:0] mem_rdata_r;
  logic              mem_ack_r;

  // A requester whose ack is still high is not re-granted for the same req.
  assign mem_elig_s = arb.mem_req & ~mem_ack_r;
  assign if_elig_s  = arb.if_req & ~if_ack_r & ~arb.flush;

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
  arb_timeout_cnt #(
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (grant_mem_s | grant_if_s),
    .enable  ((state_r != ARB_IDLE) & ~arb.bus_ack),
    .expired (expired_s)
  );
`else
  assign expired_s = 1'b0;
`endif

  // Next-state and per-cycle action decode.
  always_comb begin
    state_next_s = state_r;
    grant_mem_s  = 1'b0;
    grant_if_s   = 1'b0;
    ack_mem_s    = 1'b0;
    ack_if_s     = 1'b0;
    end_s        = 1'b0;
    err_s        = 1'b0;
    zero_data_s  = 1'b0;
    case (state_r)
      ARB_IDLE: begin
        state_next_s = arb_pick(mem_elig_s, if_elig_s);
        grant_mem_s  = mem_elig_s;
        grant_if_s   = if_elig_s & ~mem_elig_s;
      end
      ARB_BUSY_MEM: begin
        // Stores always complete; flush is ignored here.
        if (arb.bus_ack) begin
          ack_mem_s    = 1'b1;
          end_s        = 1'b1;
          state_next_s = ARB_IDLE;
        end else if (expired_s) begin
          ack_mem_s    = 1'b1;
          zero_data_s  = 1'b1;
          err_s        = 1'b1;
          end_s        = 1'b1;
          state_next_s = ARB_IDLE;
        end else begin
          state_next_s = ARB_BUSY_MEM;
        end
      end
      ARB_BUSY_IF: begin
        // A flush coinciding with completion still ends the access but hides the ack.
        if (arb.bus_ack) begin
          ack_if_s     = ~arb.flush;
          end_s        = 1'b1;
          state_next_s = ARB_IDLE;
        end else if (expired_s) begin
          ack_if_s     = ~arb.flush;
          zero_data_s  = 1'b1;
          err_s        = 1'b1;
          end_s        = 1'b1;
          state_next_s = ARB_IDLE;
        end else if (arb.flush) begin
          state_next_s = ARB_DRAIN;
        end else begin
          state_next_s = ARB_BUSY_IF;
        end
      end
      ARB_DRAIN: begin
        // The slave must still see a complete cycle; the result is discarded.
        if (arb.bus_ack) begin
          end_s        = 1'b1;
          state_next_s = ARB_IDLE;
        end else if (expired_s) begin
          err_s        = 1'b1;
          end_s        = 1'b1;
          state_next_s = ARB_IDLE;
        end else begin
          state_next_s = ARB_DRAIN;
        end
      end
      default: begin
        state_next_s = ARB_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst == `RstEnable) begin
      state_r <= ARB_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Bus request registers: loaded on grant, held through the strobe.
  always_ff @(posedge clk) begin
    if (rst == `RstEnable) begin
      bus_stb_r   <= 1'b0;
      bus_we_r    <= `WriteDisable;
      bus_addr_r  <= {ADDR_W{1'b0}};
      bus_sel_r   <= {SEL_W{1'b0}};
      bus_wdata_r <= {DATA_W{1'b0}};
      bus_err_r   <= 1'b0;
    end else begin
      bus_err_r <= err_s;
      if (grant_mem_s) begin
        bus_stb_r   <= 1'b1;
        bus_we_r    <= arb.mem_we;
        bus_addr_r  <= arb.mem_addr;
        bus_sel_r   <= arb.mem_sel;
        bus_wdata_r <= arb.mem_wdata;
      end else if (grant_if_s) begin
        bus_stb_r   <= 1'b1;
        bus_we_r    <= `WriteDisable;
        bus_addr_r  <= arb.if_addr;
        bus_sel_r   <= {SEL_W{1'b1}};
        bus_wdata_r <= {DATA_W{1'b0}};
      end else if (end_s) begin
        bus_stb_r <= 1'b0;
        bus_we_r  <= `WriteDisable;
      end
    end
  end

  // Response registers: one-cycle acks, read data held between acks.
  always_ff @(posedge clk) begin
    if (rst == `RstEnable) begin
      if_ack_r    <= 1'b0;
      mem_ack_r   <= 1'b0;
      if_rdata_r  <= {DATA_W{1'b0}};
      mem_rdata_r <= {DATA_W{1'b0}};
    end else begin
      if_ack_r  <= ack_if_s;
      mem_ack_r <= ack_mem_s;
      if (ack_if_s) begin
        if_rdata_r <= zero_data_s ? {DATA_W{1'b0}} : arb.bus_rdata;
      end
      if (ack_mem_s) begin
        // Stores return zero so a stale bus_rdata never leaks into the pipeline.
        mem_rdata_r <= (zero_data_s || (bus_we_r == `WriteEnable)) ?
                       {DATA_W{1'b0}} : arb.bus_rdata;
      end
    end
  end

  assign arb.bus_stb      = bus_stb_r;
  assign arb.bus_we       = bus_we_r;
  assign arb.bus_addr     = bus_addr_r;
  assign arb.bus_sel      = bus_sel_r;
  assign arb.bus_wdata    = bus_wdata_r;
  assign arb.bus_err      = bus_err_r;
  assign arb.if_rdata     = if_rdata_r;
  assign arb.if_ack       = if_ack_r;
  assign arb.mem_rdata    = mem_rdata_r;
  assign arb.mem_ack      = mem_ack_r;
  assign arb.stallreq_if  = arb.if_req & ~if_ack_r;
  assign arb.stallreq_mem = arb.mem_req & ~mem_ack_r;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter: reset, zero-wait load, MEM-over-IF
// priority with wait states, flush/drain, flush with ack, store byte enables,
// reset mid-transaction, dropped request, and (MEM_BUS_ARBITER_TIMEOUT_EN)
// the watchdog with TIMEOUT=4.

module tb_mem_bus_arbiter;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bif ();

  mem_bus_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .arb (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bif.flush     = 1'b0;
    bif.if_req    = 1'b0;
    bif.if_addr   = 32'h0;
    bif.mem_req   = 1'b0;
    bif.mem_we    = 1'b0;
    bif.mem_addr  = 32'h0;
    bif.mem_sel   = 4'h0;
    bif.mem_wdata = 32'h0;
    bif.bus_rdata = 32'h0;
    bif.bus_ack   = 1'b0;
    tick();
    tick();
    check("rst_stb", {31'h0, bif.bus_stb}, 32'h0);
    check("rst_if_ack", {31'h0, bif.if_ack}, 32'h0);
    check("rst_mem_ack", {31'h0, bif.mem_ack}, 32'h0);
    check("rst_err", {31'h0, bif.bus_err}, 32'h0);
    check("rst_addr", bif.bus_addr, 32'h0);
    check("rst_mem_rdata", bif.mem_rdata, 32'h0);
    rst = 1'b0;
    tick();

    // Single load, zero-wait slave
    bif.mem_req = 1'b1; bif.mem_we = 1'b0; bif.mem_addr = 32'h100; bif.mem_sel = 4'hF;
    #1;
    check("ld_stall", {31'h0, bif.stallreq_mem}, 32'h1);
    tick();
    check("ld_stb", {31'h0, bif.bus_stb}, 32'h1);
    check("ld_addr", bif.bus_addr, 32'h100);
    check("ld_we", {31'h0, bif.bus_we}, 32'h0);
    check("ld_ack_early", {31'h0, bif.mem_ack}, 32'h0);
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'hDEADBEEF;
    tick();
    check("ld_ack", {31'h0, bif.mem_ack}, 32'h1);
    check("ld_rdata", bif.mem_rdata, 32'hDEADBEEF);
    check("ld_stb_off", {31'h0, bif.bus_stb}, 32'h0);
    bif.mem_req = 1'b0; bif.bus_ack = 1'b0;
    tick();
    check("ld_ack_pulse", {31'h0, bif.mem_ack}, 32'h0);
    check("ld_rdata_hold", bif.mem_rdata, 32'hDEADBEEF);

    // Simultaneous requests, 3 wait states each
    bif.if_req = 1'b1; bif.if_addr = 32'h200;
    bif.mem_req = 1'b1; bif.mem_addr = 32'h300;
    #1;
    check("sim_stall_if", {31'h0, bif.stallreq_if}, 32'h1);
    tick();
    check("sim_mem_first", bif.bus_addr, 32'h300);
    check("sim_stb", {31'h0, bif.bus_stb}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sim_stall_if_wait", {31'h0, bif.stallreq_if}, 32'h1);
      check("sim_mem_wait_stb", {31'h0, bif.bus_stb}, 32'h1);
    end
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'hA5A50001;
    tick();
    check("sim_mem_ack", {31'h0, bif.mem_ack}, 32'h1);
    check("sim_mem_rdata", bif.mem_rdata, 32'hA5A50001);
    check("sim_if_no_ack", {31'h0, bif.if_ack}, 32'h0);
    check("sim_stall_mem_off", {31'h0, bif.stallreq_mem}, 32'h0);
    check("sim_stall_if_hold", {31'h0, bif.stallreq_if}, 32'h1);
    bif.bus_ack = 1'b0;
    // mem_req still high during its ack cycle: must not be granted again
    tick();
    check("sim_if_grant", bif.bus_addr, 32'h200);
    check("sim_if_stb", {31'h0, bif.bus_stb}, 32'h1);
    check("sim_if_sel", {28'h0, bif.bus_sel}, 32'hF);
    check("sim_mem_ack_off", {31'h0, bif.mem_ack}, 32'h0);
    bif.mem_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sim_if_wait", {31'h0, bif.if_ack}, 32'h0);
    end
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'h0BADF00D;
    tick();
    check("sim_if_ack", {31'h0, bif.if_ack}, 32'h1);
    check("sim_if_rdata", bif.if_rdata, 32'h0BADF00D);
    check("sim_stall_if_off", {31'h0, bif.stallreq_if}, 32'h0);
    bif.if_req = 1'b0; bif.bus_ack = 1'b0;
    tick();
    check("sim_if_ack_pulse", {31'h0, bif.if_ack}, 32'h0);

    // Flush mid-fetch, 2 wait states
    bif.if_req = 1'b1; bif.if_addr = 32'h400;
    tick();
    check("fl_stb", {31'h0, bif.bus_stb}, 32'h1);
    bif.flush = 1'b1;
    tick();
    bif.flush = 1'b0; bif.if_req = 1'b0;
    check("fl_drain_stb", {31'h0, bif.bus_stb}, 32'h1);
    check("fl_drain_addr", bif.bus_addr, 32'h400);
    tick();
    check("fl_drain_stb2", {31'h0, bif.bus_stb}, 32'h1);
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'h11111111;
    tick();
    check("fl_stb_off", {31'h0, bif.bus_stb}, 32'h0);
    check("fl_no_ack", {31'h0, bif.if_ack}, 32'h0);
    check("fl_rdata_keep", bif.if_rdata, 32'h0BADF00D);
    bif.bus_ack = 1'b0;
    tick();
    check("fl_no_ack2", {31'h0, bif.if_ack}, 32'h0);

    // Flush arriving together with bus_ack
    bif.if_req = 1'b1; bif.if_addr = 32'h500;
    tick();
    check("fa_stb", {31'h0, bif.bus_stb}, 32'h1);
    bif.flush = 1'b1; bif.bus_ack = 1'b1; bif.bus_rdata = 32'h22222222;
    tick();
    check("fa_stb_off", {31'h0, bif.bus_stb}, 32'h0);
    check("fa_no_ack", {31'h0, bif.if_ack}, 32'h0);
    check("fa_rdata_keep", bif.if_rdata, 32'h0BADF00D);
    bif.flush = 1'b0; bif.bus_ack = 1'b0; bif.if_req = 1'b0;
    tick();
    check("fa_idle", {31'h0, bif.bus_stb}, 32'h0);

    // Store with byte enables, 1 wait state
    bif.mem_req = 1'b1; bif.mem_we = 1'b1; bif.mem_addr = 32'h600;
    bif.mem_sel = 4'b0011; bif.mem_wdata = 32'h1234ABCD;
    tick();
    check("st_we", {31'h0, bif.bus_we}, 32'h1);
    check("st_sel", {28'h0, bif.bus_sel}, 32'h3);
    check("st_wdata", bif.bus_wdata, 32'h1234ABCD);
    tick();
    check("st_we_hold", {31'h0, bif.bus_we}, 32'h1);
    check("st_sel_hold", {28'h0, bif.bus_sel}, 32'h3);
    check("st_wdata_hold", bif.bus_wdata, 32'h1234ABCD);
    check("st_stb_hold", {31'h0, bif.bus_stb}, 32'h1);
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'hFFFFFFFF;
    tick();
    check("st_ack", {31'h0, bif.mem_ack}, 32'h1);
    check("st_rdata_zero", bif.mem_rdata, 32'h0);
    check("st_stb_off", {31'h0, bif.bus_stb}, 32'h0);
    bif.mem_req = 1'b0; bif.mem_we = 1'b0; bif.bus_ack = 1'b0;
    tick();
    check("st_ack_pulse", {31'h0, bif.mem_ack}, 32'h0);

    // Reset while a fetch is in flight
    bif.if_req = 1'b1; bif.if_addr = 32'h700;
    tick();
    check("rm_stb", {31'h0, bif.bus_stb}, 32'h1);
    rst = 1'b1;
    tick();
    check("rm_stb_off", {31'h0, bif.bus_stb}, 32'h0);
    check("rm_no_if_ack", {31'h0, bif.if_ack}, 32'h0);
    check("rm_if_rdata", bif.if_rdata, 32'h0);
    check("rm_addr", bif.bus_addr, 32'h0);
    rst = 1'b0;
    tick();
    check("rm_regrant", bif.bus_addr, 32'h700);
    check("rm_regrant_stb", {31'h0, bif.bus_stb}, 32'h1);
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'h77770000;
    tick();
    check("rm_if_ack", {31'h0, bif.if_ack}, 32'h1);
    check("rm_if_rdata2", bif.if_rdata, 32'h77770000);
    bif.if_req = 1'b0; bif.bus_ack = 1'b0;
    tick();

    // MEM drops req mid-transaction: access still completes
    bif.mem_req = 1'b1; bif.mem_addr = 32'h800; bif.mem_sel = 4'hF;
    tick();
    bif.mem_req = 1'b0;
    tick();
    check("dr_stb_hold", {31'h0, bif.bus_stb}, 32'h1);
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'h00000088;
    tick();
    check("dr_ack", {31'h0, bif.mem_ack}, 32'h1);
    check("dr_rdata", bif.mem_rdata, 32'h00000088);
    check("dr_err", {31'h0, bif.bus_err}, 32'h0);
    bif.bus_ack = 1'b0;
    tick();

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
    // Slave never acks: abort after TIMEOUT=4 wait cycles
    bif.mem_req = 1'b1; bif.mem_addr = 32'h900;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("to_stb_wait", {31'h0, bif.bus_stb}, 32'h1);
      check("to_err_wait", {31'h0, bif.bus_err}, 32'h0);
    end
    tick();
    check("to_err", {31'h0, bif.bus_err}, 32'h1);
    check("to_ack", {31'h0, bif.mem_ack}, 32'h1);
    check("to_rdata", bif.mem_rdata, 32'h0);
    check("to_stb_off", {31'h0, bif.bus_stb}, 32'h0);
    bif.mem_req = 1'b0;
    tick();
    check("to_err_pulse", {31'h0, bif.bus_err}, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
